adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 The block SHALL have no parameters; all operand widths are fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a  input  4  unsigned operand A.
REQ-005 b  input  4  unsigned operand B.
REQ-006 c  input  4  carry-in vector; c[0] is the carry-in, c[3:1] are ignored.
REQ-007 s  output  4  registered sum bits [3:0].
REQ-008 cout  output  1  registered carry-out (sum bit 4).
REQ-009 hex_a  output  7  registered 7-segment pattern of a.
REQ-010 hex_b  output  7  registered 7-segment pattern of b.
REQ-011 hex_s  output  7  registered 7-segment pattern of s.

Function
REQ-012 On each rising clk edge with rst low, {cout,s} SHALL load a + b + c[0], computed at 5-bit width with no overflow loss.
REQ-013 Latency SHALL be exactly one clock from a/b/c sampled to s/cout/hex_* valid; there is no handshake, and a new operation is accepted every cycle.
REQ-014 hex_a and hex_b SHALL be the encodings of a and b sampled on the same edge as the sum, so all five outputs are mutually consistent.
REQ-015 hex_s SHALL be the encoding of the sum value registered on the same edge, not of the previous s.
REQ-016 Segment patterns SHALL be active-low (0 = lit), with bit0 = seg a, bit1 = b, bit2 = c, bit3 = d, bit4 = e, bit5 = f and bit6 = g.
REQ-017 The encoding SHALL be, in hex as 7-bit values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-018 Wrap-around: for sums ≥16, s SHALL equal the sum mod 16, cout SHALL be 1, and hex_s SHALL show s.
REQ-019 Bits c[3:1] SHALL have no effect on any output.
REQ-020 No output SHALL depend combinationally on any input.

Reset
REQ-021 While rst is high at a rising edge, the block SHALL load s=0 and cout=0.
REQ-022 While rst is high at a rising edge, the block SHALL load hex_a = hex_b = hex_s = 7'h40 (digit 0).
REQ-023 Reset SHALL take priority over input sampling.
REQ-024 Asserting reset mid-stream SHALL discard the in-flight result.
REQ-025 The first edge after rst falls SHALL register the inputs present at that edge.
REQ-026 The block SHALL have no asynchronous reset path.

Structure
REQ-027 A shared package SHALL hold the 16 segment-pattern constants (SEG_0..SEG_F) and the blank/reset pattern constant.
REQ-028 Sub-module translator SHALL be a purely combinational 4-bit to 7-bit decoder implementing REQ-016 and REQ-017.
REQ-029 adder SHALL instantiate translator three times (for a, b and the next-sum value).
REQ-030 The sum SHALL be built as a 4-stage ripple of full-adder logic or an equivalent single 5-bit addition; either is acceptable.

Verification
REQ-031 Reset scenario: rst=1 for 2 edges with random inputs -> s=0, cout=0, all hex_*=40.
REQ-032 Basic add: a=7, b=8, c=0 -> after 1 edge s=F, cout=0, hex_a=78, hex_b=00, hex_s=0E.
REQ-033 Wrap-around: a=F, b=1, c=0 -> s=0, cout=1, hex_s=40.
REQ-034 Carry-in and ignored bits: a=F, b=F, c=4'hF -> s=F, cout=1; the result is identical with c=4'h1.
REQ-035 Exhaustive sweep: all 512 (a, b, c[0]) combinations back-to-back, one per cycle -> each result matches a+b+c[0] exactly one cycle later and each hex_* matches the REQ-017 table.
REQ-036 Reset mid-stream: apply a=3, b=4, assert rst on the next edge -> outputs are zero/40 rather than 7; with rst then low and a=3, b=4 held, s=7 one edge later.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the registered 4-bit adder with 7-segment readouts.
// Segment patterns are active-low (0 = lit), with bit0..bit6 = segments a..g.
package adder_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEG_W  = 7;

    // Digit patterns for 0..F
    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

    // Pattern loaded while in reset: the displays read "0", matching s = 0.
    localparam logic [SEG_W-1:0] SEG_RESET = SEG_0;

    // All segments dark; used only as a safe decoder default.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/adder_translator.sv
// Combinational hex-digit to 7-segment decoder (active-low segments).
module translator
    import adder_pkg::*;
(
    input  logic [DATA_W-1:0] i_digit,
    output logic [SEG_W-1:0]  o_seg
);

    // Look up the segment pattern for the 4-bit digit.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder.sv
// Registered 4-bit ripple-carry adder with carry-in and three 7-segment
// readouts (operand A, operand B, sum). All outputs are registered on the
// same edge, so they always describe the same operation, one clock after
// the operands were presented.
module adder
    import adder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] s,
    output logic              cout,
    output logic [SEG_W-1:0]  hex_a,
    output logic [SEG_W-1:0]  hex_b,
    output logic [SEG_W-1:0]  hex_s
);

    // Ripple chain: w_carry[0] is the carry-in, w_carry[DATA_W] the carry-out.
    logic [DATA_W:0]   w_carry;
    logic [DATA_W-1:0] w_sum;
    logic [SEG_W-1:0]  w_seg_a;
    logic [SEG_W-1:0]  w_seg_b;
    logic [SEG_W-1:0]  w_seg_s;

    // Only c[0] participates; the upper bits are deliberately ignored.
    logic w_unused_c;
    assign w_unused_c = ^c[DATA_W-1:1];

    assign w_carry[0] = c[0];

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fa
            assign w_sum[gi]      = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1]  = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    // The sum display decodes the next-sum value so it lands with s itself.
    translator u_tr_a (.i_digit(a),     .o_seg(w_seg_a));
    translator u_tr_b (.i_digit(b),     .o_seg(w_seg_b));
    translator u_tr_s (.i_digit(w_sum), .o_seg(w_seg_s));

    logic [DATA_W-1:0] r_s;
    logic              r_cout;
    logic [SEG_W-1:0]  r_hex_a;
    logic [SEG_W-1:0]  r_hex_b;
    logic [SEG_W-1:0]  r_hex_s;

    // Output register: reset wins, otherwise capture this cycle's operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_hex_a <= SEG_RESET;
            r_hex_b <= SEG_RESET;
            r_hex_s <= SEG_RESET;
        end else begin
            r_s     <= w_sum;
            r_cout  <= w_carry[DATA_W];
            r_hex_a <= w_seg_a;
            r_hex_b <= w_seg_b;
            r_hex_s <= w_seg_s;
        end
    end

    assign s     = r_s;
    assign cout  = r_cout;
    assign hex_a = r_hex_a;
    assign hex_b = r_hex_b;
    assign hex_s = r_hex_s;

endmodule

// File: tb/tb_adder.sv
// Directed bench for the registered adder: reset, basic add, wrap-around,
// carry-in with ignored bits, exhaustive sweep and mid-stream reset.
module tb_adder;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] s;
    logic       cout;
    logic [6:0] hex_a;
    logic [6:0] hex_b;
    logic [6:0] hex_s;

    int n_total;
    int n_bad;

    adder dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .s     (s),
        .cout  (cout),
        .hex_a (hex_a),
        .hex_b (hex_b),
        .hex_s (hex_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment table, transcribed from the digit encoding list.
    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one operation, clock it in, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [3:0] va, input logic [3:0] vb,
                        input logic [3:0] vc);
        rst = r; a = va; b = vb; c = vc;
        @(posedge clk);
        #1;
        $display("txn rst=%0b a=%h b=%h c=%h -> s=%h cout=%0b hex_a=%h hex_b=%h hex_s=%h",
                 r, va, vb, vc, s, cout, hex_a, hex_b, hex_s);
    endtask

    task automatic check_all(input string tag, input logic [3:0] es, input logic ec,
                             input logic [6:0] ea, input logic [6:0] eb, input logic [6:0] ehs);
        check({tag, ".s"},     32'(s),     32'(es));
        check({tag, ".cout"},  32'(cout),  32'(ec));
        check({tag, ".hex_a"}, 32'(hex_a), 32'(ea));
        check({tag, ".hex_b"}, 32'(hex_b), 32'(eb));
        check({tag, ".hex_s"}, 32'(hex_s), 32'(ehs));
    endtask

    initial begin
        logic [4:0] tot;
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1; a = '0; b = '0; c = '0;
        #2;

        // Reset for two edges with random operands.
        step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
        check_all("rst1", 4'h0, 1'b0, 7'h40, 7'h40, 7'h40);
        step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
        check_all("rst2", 4'h0, 1'b0, 7'h40, 7'h40, 7'h40);

        // Basic add 7 + 8 = F.
        step(1'b0, 4'h7, 4'h8, 4'h0);
        check_all("basic", 4'hF, 1'b0, 7'h78, 7'h00, 7'h0E);

        // Wrap-around F + 1 = 0x10.
        step(1'b0, 4'hF, 4'h1, 4'h0);
        check_all("wrap", 4'h0, 1'b1, 7'h0E, 7'h79, 7'h40);

        // Carry-in with upper c bits set: F + F + 1 = 0x1F.
        step(1'b0, 4'hF, 4'hF, 4'hF);
        check_all("cin_f", 4'hF, 1'b1, 7'h0E, 7'h0E, 7'h0E);
        step(1'b0, 4'hF, 4'hF, 4'h1);
        check_all("cin_1", 4'hF, 1'b1, 7'h0E, 7'h0E, 7'h0E);
        // Upper c bits alone must not act as carry-in: 2 + 3 + 0 = 5.
        step(1'b0, 4'h2, 4'h3, 4'hE);
        check_all("c_hi", 4'h5, 1'b0, 7'h24, 7'h30, 7'h12);

        // Exhaustive sweep, one operation per cycle.
        for (int i = 0; i < 512; i++) begin
            logic [3:0] va, vb;
            logic       vc;
            va = 4'(i >> 5);
            vb = 4'(i >> 1);
            vc = 1'(i);
            tot = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
            step(1'b0, va, vb, {3'(i >> 3), vc});
            check_all("sweep", tot[3:0], tot[4], seg_ref(va), seg_ref(vb), seg_ref(tot[3:0]));
        end

        // Mid-stream reset discards 3 + 4, then the held inputs register.
        step(1'b0, 4'h1, 4'h1, 4'h0);
        check_all("pre", 4'h2, 1'b0, 7'h79, 7'h79, 7'h24);
        step(1'b1, 4'h3, 4'h4, 4'h0);
        check_all("midrst", 4'h0, 1'b0, 7'h40, 7'h40, 7'h40);
        step(1'b0, 4'h3, 4'h4, 4'h0);
        check_all("release", 4'h7, 1'b0, 7'h30, 7'h19, 7'h78);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
